// File: rtl/mmio_region_router.sv
// Registered MMIO router: decodes a host word index into one of NUM_REGIONS device
// ports, holds the request until the device acks, and errors on unmapped or timed-out accesses.

module mmio_region_channel #(
    parameter int NUM_REGIONS = 4,
    parameter int INDEX_WIDTH = 32,
    parameter logic [NUM_REGIONS*INDEX_WIDTH-1:0] REGION_BASES  = '0,
    parameter logic [NUM_REGIONS*INDEX_WIDTH-1:0] REGION_BOUNDS = '0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   host_req,
    input  logic [INDEX_WIDTH-1:0] host_index,
    output logic                   host_ack,
    output logic                   host_error,
    output logic [NUM_REGIONS-1:0] dev_req,
    output logic [INDEX_WIDTH-1:0] dev_index,
    input  logic [NUM_REGIONS-1:0] dev_ack,
    output logic [15:0]            error_count
);
    // state | meaning
    // IDLE  | waiting for a host request
    // BUSY  | device request outstanding, timeout timer running
    // DONE  | ack issued, waiting for host to drop its request
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD =
        TIMER_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                 state, state_nx;
    logic [NUM_REGIONS-1:0] sel, sel_nx;
    logic [INDEX_WIDTH-1:0] offset_nx;
    logic [TIMER_W-1:0]     timer, timer_nx;
    logic                   ack_nx, error_nx;
    logic [15:0]            count_nx;

    logic                   hit;
    logic [NUM_REGIONS-1:0] hit_sel;
    logic [INDEX_WIDTH-1:0] hit_offset;

    // Ascending scan with a found flag so the lowest region wins on overlap.
    always_comb begin
        hit        = 1'b0;
        hit_sel    = '0;
        hit_offset = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (!hit &&
                host_index >= REGION_BASES[r*INDEX_WIDTH +: INDEX_WIDTH] &&
                host_index <  REGION_BOUNDS[r*INDEX_WIDTH +: INDEX_WIDTH]) begin
                hit        = 1'b1;
                hit_sel[r] = 1'b1;
                hit_offset = host_index - REGION_BASES[r*INDEX_WIDTH +: INDEX_WIDTH];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        sel_nx    = sel;
        offset_nx = dev_index;
        timer_nx  = timer;
        ack_nx    = 1'b0;
        error_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (host_req) begin
                    if (hit) begin
                        sel_nx    = hit_sel;
                        offset_nx = hit_offset;
                        timer_nx  = TIMER_LOAD;
                        state_nx  = BUSY;
                    end else begin
                        ack_nx   = 1'b1;
                        error_nx = 1'b1;
                        state_nx = DONE;
                    end
                end
            end
            BUSY: begin
                if (|(dev_ack & sel)) begin
                    ack_nx   = 1'b1;
                    state_nx = DONE;
                end else if (TIMEOUT_CYCLES != 0 && timer == '0) begin
                    ack_nx   = 1'b1;
                    error_nx = 1'b1;
                    state_nx = DONE;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            DONE: begin
                if (!host_req)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        count_nx = (error_nx && error_count != 16'hFFFF) ? error_count + 16'd1 : error_count;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= '0;
            dev_index   <= '0;
            timer       <= '0;
            host_ack    <= 1'b0;
            host_error  <= 1'b0;
            error_count <= '0;
        end else begin
            state       <= state_nx;
            sel         <= sel_nx;
            dev_index   <= offset_nx;
            timer       <= timer_nx;
            host_ack    <= ack_nx;
            host_error  <= error_nx;
            error_count <= count_nx;
        end
    end

    // Request is gated by state so a reset or completion drops it immediately.
    assign dev_req = (state == BUSY) ? sel : '0;

endmodule

module mmio_region_router #(
    parameter int NUM_REGIONS = 4,
    parameter int INDEX_WIDTH = 32,
    parameter int DATA_WIDTH  = 32,
    parameter logic [NUM_REGIONS*INDEX_WIDTH-1:0] REGION_BASES  = {NUM_REGIONS{INDEX_WIDTH'(0)}},
    parameter logic [NUM_REGIONS*INDEX_WIDTH-1:0] REGION_BOUNDS = {NUM_REGIONS{INDEX_WIDTH'(0)}},
    parameter int TIMEOUT_CYCLES = 256,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA = 32'hDEAD_BEEF
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              host_read_req,
    input  logic [INDEX_WIDTH-1:0]            host_read_index,
    output logic                              host_read_ack,
    output logic [DATA_WIDTH-1:0]             host_read_data,
    output logic                              host_read_error,
    input  logic                              host_write_req,
    input  logic [INDEX_WIDTH-1:0]            host_write_index,
    input  logic [DATA_WIDTH-1:0]             host_write_data,
    output logic                              host_write_ack,
    output logic                              host_write_error,
    output logic [NUM_REGIONS-1:0]            dev_read_req,
    output logic [INDEX_WIDTH-1:0]            dev_read_index,
    input  logic [NUM_REGIONS-1:0]            dev_read_ack,
    input  logic [NUM_REGIONS*DATA_WIDTH-1:0] dev_read_data,
    output logic [NUM_REGIONS-1:0]            dev_write_req,
    output logic [INDEX_WIDTH-1:0]            dev_write_index,
    output logic [DATA_WIDTH-1:0]             dev_write_data,
    input  logic [NUM_REGIONS-1:0]            dev_write_ack,
    output logic [15:0]                       read_error_count,
    output logic [15:0]                       write_error_count
);
    logic [DATA_WIDTH-1:0] rdata_q, rdata_nx;
    logic [DATA_WIDTH-1:0] wdata_q;

    mmio_region_channel #(
        .NUM_REGIONS(NUM_REGIONS), .INDEX_WIDTH(INDEX_WIDTH),
        .REGION_BASES(REGION_BASES), .REGION_BOUNDS(REGION_BOUNDS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_read (
        .clock(clock), .reset(reset),
        .host_req(host_read_req), .host_index(host_read_index),
        .host_ack(host_read_ack), .host_error(host_read_error),
        .dev_req(dev_read_req), .dev_index(dev_read_index),
        .dev_ack(dev_read_ack), .error_count(read_error_count)
    );

    mmio_region_channel #(
        .NUM_REGIONS(NUM_REGIONS), .INDEX_WIDTH(INDEX_WIDTH),
        .REGION_BASES(REGION_BASES), .REGION_BOUNDS(REGION_BOUNDS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_write (
        .clock(clock), .reset(reset),
        .host_req(host_write_req), .host_index(host_write_index),
        .host_ack(host_write_ack), .host_error(host_write_error),
        .dev_req(dev_write_req), .dev_index(dev_write_index),
        .dev_ack(dev_write_ack), .error_count(write_error_count)
    );

    // dev_read_req is only non-zero in BUSY, so this matches the channel's completion condition.
    always_comb begin
        rdata_nx = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (dev_read_req[r] && dev_read_ack[r])
                rdata_nx = dev_read_data[r*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
            wdata_q <= '0;
        end else begin
            rdata_q <= rdata_nx;
            // Frozen while the write is outstanding; otherwise tracks the host.
            if (dev_write_req == '0)
                wdata_q <= host_write_data;
        end
    end

    assign host_read_data = host_read_error ? ERROR_DATA : rdata_q;
    assign dev_write_data = wdata_q;

endmodule

// File: tb/tb_mmio_region_router.sv
// Directed bench for mmio_region_router: hit, miss, timeout, concurrency, boundaries, reset.

module tb_mmio_region_router;
    localparam int N  = 4;
    localparam int IW = 32;
    localparam int DW = 32;

    logic           clock = 1'b0;
    logic           reset;
    logic           host_read_req;
    logic [IW-1:0]  host_read_index;
    logic           host_read_ack;
    logic [DW-1:0]  host_read_data;
    logic           host_read_error;
    logic           host_write_req;
    logic [IW-1:0]  host_write_index;
    logic [DW-1:0]  host_write_data;
    logic           host_write_ack;
    logic           host_write_error;
    logic [N-1:0]   dev_read_req;
    logic [IW-1:0]  dev_read_index;
    logic [N-1:0]   dev_read_ack;
    logic [N*DW-1:0] dev_read_data;
    logic [N-1:0]   dev_write_req;
    logic [IW-1:0]  dev_write_index;
    logic [DW-1:0]  dev_write_data;
    logic [N-1:0]   dev_write_ack;
    logic [15:0]    read_error_count;
    logic [15:0]    write_error_count;

    int vectors = 0;
    int miscompares = 0;

    mmio_region_router #(
        .NUM_REGIONS(N), .INDEX_WIDTH(IW), .DATA_WIDTH(DW),
        .REGION_BASES ({32'h4010_0000, 32'h4000_1000, 32'h4000_0010, 32'h4000_0000}),
        .REGION_BOUNDS({32'h4011_0000, 32'h4010_0000, 32'h4000_1000, 32'h4000_0010}),
        .TIMEOUT_CYCLES(8),
        .ERROR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clock(clock), .reset(reset),
        .host_read_req(host_read_req), .host_read_index(host_read_index),
        .host_read_ack(host_read_ack), .host_read_data(host_read_data),
        .host_read_error(host_read_error),
        .host_write_req(host_write_req), .host_write_index(host_write_index),
        .host_write_data(host_write_data), .host_write_ack(host_write_ack),
        .host_write_error(host_write_error),
        .dev_read_req(dev_read_req), .dev_read_index(dev_read_index),
        .dev_read_ack(dev_read_ack), .dev_read_data(dev_read_data),
        .dev_write_req(dev_write_req), .dev_write_index(dev_write_index),
        .dev_write_data(dev_write_data), .dev_write_ack(dev_write_ack),
        .read_error_count(read_error_count), .write_error_count(write_error_count)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        host_read_req = 0; host_read_index = '0;
        host_write_req = 0; host_write_index = '0; host_write_data = '0;
        dev_read_ack = '0; dev_read_data = '0; dev_write_ack = '0;
        next_cycle();
        next_cycle();
        vectors++; if ({host_read_ack, host_read_error, host_write_ack, host_write_error} !== 4'b0) begin miscompares++; $display("FAIL reset_acks: got %b want 0000", {host_read_ack, host_read_error, host_write_ack, host_write_error}); end
        vectors++; if ({dev_read_req, dev_write_req} !== 8'h00) begin miscompares++; $display("FAIL reset_dev_req: got %h want 00", {dev_read_req, dev_write_req}); end
        vectors++; if (host_read_data !== '0 || read_error_count !== 16'd0 || write_error_count !== 16'd0) begin miscompares++; $display("FAIL reset_data_counts: got %h/%h/%h want 0/0/0", host_read_data, read_error_count, write_error_count); end
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_read_hit();
        host_read_req = 1; host_read_index = 32'h4000_0012;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            vectors++; if (dev_read_req !== 4'b0010 || dev_read_index !== 32'd2) begin miscompares++; $display("FAIL rd_hit_dev c%0d: got req %b idx %h want 0010 2", c, dev_read_req, dev_read_index); end
            vectors++; if (host_read_ack !== 1'b0) begin miscompares++; $display("FAIL rd_hit_early_ack c%0d: got %b want 0", c, host_read_ack); end
        end
        dev_read_ack = 4'b0010; dev_read_data[1*DW +: DW] = 32'h1234_5678;
        next_cycle();
        vectors++; if ({host_read_ack, host_read_error} !== 2'b10 || host_read_data !== 32'h1234_5678) begin miscompares++; $display("FAIL rd_hit_ack: got ack/err %b data %h want 10 12345678", {host_read_ack, host_read_error}, host_read_data); end
        vectors++; if (dev_read_req !== 4'b0000) begin miscompares++; $display("FAIL rd_hit_req_drop: got %b want 0000", dev_read_req); end
        dev_read_ack = '0; host_read_req = 0;
        next_cycle();
        vectors++; if (host_read_ack !== 1'b0 || host_read_data !== '0) begin miscompares++; $display("FAIL rd_hit_ack_pulse: got %b %h want 0 0", host_read_ack, host_read_data); end
    endtask

    task automatic test_write_hit();
        host_write_req = 1; host_write_index = 32'h4010_FFFF; host_write_data = 32'hA5A5_A5A5;
        next_cycle();
        vectors++; if (dev_write_req !== 4'b1000 || dev_write_index !== 32'h0000_FFFF || dev_write_data !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL wr_hit_dev: got %b %h %h want 1000 0000ffff a5a5a5a5", dev_write_req, dev_write_index, dev_write_data); end
        dev_write_ack = 4'b1000;
        next_cycle();
        vectors++; if ({host_write_ack, host_write_error} !== 2'b10 || dev_write_req !== 4'b0000) begin miscompares++; $display("FAIL wr_hit_ack: got %b req %b want 10 0000", {host_write_ack, host_write_error}, dev_write_req); end
        dev_write_ack = '0; host_write_req = 0;
        next_cycle();
        vectors++; if (host_write_ack !== 1'b0) begin miscompares++; $display("FAIL wr_hit_ack_pulse: got %b want 0", host_write_ack); end
    endtask

    task automatic test_read_unmapped();
        host_read_req = 1; host_read_index = 32'h3FFF_FFFF;
        next_cycle();
        vectors++; if ({host_read_ack, host_read_error} !== 2'b11 || host_read_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_miss_ack: got %b %h want 11 deadbeef", {host_read_ack, host_read_error}, host_read_data); end
        vectors++; if (dev_read_req !== 4'b0000 || read_error_count !== 16'd1) begin miscompares++; $display("FAIL rd_miss_req_count: got %b %0d want 0000 1", dev_read_req, read_error_count); end
        host_read_req = 0;
        next_cycle();
        vectors++; if ({host_read_ack, host_read_error} !== 2'b00 || host_read_data !== '0) begin miscompares++; $display("FAIL rd_miss_pulse: got %b %h want 00 0", {host_read_ack, host_read_error}, host_read_data); end
    endtask

    task automatic test_write_timeout();
        host_write_req = 1; host_write_index = 32'h4000_2000; host_write_data = 32'h0000_0011;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            vectors++; if (dev_write_req !== 4'b0100 || host_write_ack !== 1'b0) begin miscompares++; $display("FAIL wr_to_busy c%0d: got req %b ack %b want 0100 0", c, dev_write_req, host_write_ack); end
        end
        next_cycle();
        vectors++; if ({host_write_ack, host_write_error} !== 2'b11 || dev_write_req !== 4'b0000) begin miscompares++; $display("FAIL wr_to_ack: got %b req %b want 11 0000", {host_write_ack, host_write_error}, dev_write_req); end
        vectors++; if (write_error_count !== 16'd1) begin miscompares++; $display("FAIL wr_to_count: got %0d want 1", write_error_count); end
        host_write_req = 0; dev_write_ack = 4'b0100;
        for (int c = 10; c <= 11; c++) begin
            next_cycle();
            vectors++; if ({host_write_ack, host_write_error} !== 2'b00 || write_error_count !== 16'd1) begin miscompares++; $display("FAIL wr_late_ack c%0d: got %b cnt %0d want 00 1", c, {host_write_ack, host_write_error}, write_error_count); end
        end
        dev_write_ack = '0;
        next_cycle();
    endtask

    task automatic test_concurrent();
        host_read_req = 1;  host_read_index = 32'h4000_0005;
        host_write_req = 1; host_write_index = 32'h4000_1234; host_write_data = 32'hCAFE_F00D;
        next_cycle();
        vectors++; if (dev_read_req !== 4'b0001 || dev_read_index !== 32'd5) begin miscompares++; $display("FAIL cc_rd_dev: got %b %h want 0001 5", dev_read_req, dev_read_index); end
        vectors++; if (dev_write_req !== 4'b0100 || dev_write_index !== 32'h234 || dev_write_data !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL cc_wr_dev: got %b %h %h want 0100 234 cafef00d", dev_write_req, dev_write_index, dev_write_data); end
        dev_read_ack = 4'b0001; dev_read_data[0 +: DW] = 32'h0BAD_F00D;
        next_cycle();
        vectors++; if ({host_read_ack, host_read_error} !== 2'b10 || host_read_data !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL cc_rd_ack: got %b %h want 10 0badf00d", {host_read_ack, host_read_error}, host_read_data); end
        vectors++; if (host_write_ack !== 1'b0 || dev_write_req !== 4'b0100) begin miscompares++; $display("FAIL cc_wr_wait: got ack %b req %b want 0 0100", host_write_ack, dev_write_req); end
        dev_read_ack = '0; host_read_req = 0; dev_write_ack = 4'b0100;
        next_cycle();
        vectors++; if ({host_write_ack, host_write_error} !== 2'b10 || host_read_ack !== 1'b0) begin miscompares++; $display("FAIL cc_wr_ack: got %b rd_ack %b want 10 0", {host_write_ack, host_write_error}, host_read_ack); end
        dev_write_ack = '0; host_write_req = 0;
        next_cycle();
    endtask

    task automatic test_boundaries();
        host_read_req = 1; host_read_index = 32'h4000_0010;
        next_cycle();
        vectors++; if (dev_read_req !== 4'b0010 || dev_read_index !== 32'd0) begin miscompares++; $display("FAIL bnd_base: got %b %h want 0010 0", dev_read_req, dev_read_index); end
        dev_read_ack = 4'b0011; dev_read_data[0 +: DW] = 32'h1111_1111; dev_read_data[1*DW +: DW] = 32'h2222_2222;
        next_cycle();
        vectors++; if (host_read_ack !== 1'b1 || host_read_data !== 32'h2222_2222) begin miscompares++; $display("FAIL bnd_base_data: got %b %h want 1 22222222", host_read_ack, host_read_data); end
        dev_read_ack = '0; host_read_req = 0;
        next_cycle();
        host_read_req = 1; host_read_index = 32'h4011_0000;
        next_cycle();
        vectors++; if ({host_read_ack, host_read_error} !== 2'b11 || dev_read_req !== 4'b0000 || read_error_count !== 16'd2) begin miscompares++; $display("FAIL bnd_bound_miss: got %b req %b cnt %0d want 11 0000 2", {host_read_ack, host_read_error}, dev_read_req, read_error_count); end
        host_read_req = 0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        host_read_req = 1; host_read_index = 32'h4010_0004;
        next_cycle();
        vectors++; if (dev_read_req !== 4'b1000 || dev_read_index !== 32'd4) begin miscompares++; $display("FAIL rst_mid_busy: got %b %h want 1000 4", dev_read_req, dev_read_index); end
        reset = 1'b1;
        #1;
        vectors++; if (dev_read_req !== 4'b0000 || dev_read_index !== '0 || host_read_ack !== 1'b0) begin miscompares++; $display("FAIL rst_mid_drop: got %b %h %b want 0000 0 0", dev_read_req, dev_read_index, host_read_ack); end
        vectors++; if (read_error_count !== 16'd0 || write_error_count !== 16'd0) begin miscompares++; $display("FAIL rst_mid_counts: got %0d %0d want 0 0", read_error_count, write_error_count); end
        host_read_req = 0;
        next_cycle();
        reset = 1'b0;
        next_cycle();
        vectors++; if (host_read_ack !== 1'b0 || dev_read_req !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_no_ack: got %b %b want 0 0000", host_read_ack, dev_read_req); end
        host_read_req = 1; host_read_index = 32'h4000_0003;
        next_cycle();
        vectors++; if (dev_read_req !== 4'b0001 || dev_read_index !== 32'd3) begin miscompares++; $display("FAIL rst_mid_idle: got %b %h want 0001 3", dev_read_req, dev_read_index); end
        dev_read_ack = 4'b0001; dev_read_data[0 +: DW] = 32'h0000_00A3;
        next_cycle();
        vectors++; if ({host_read_ack, host_read_error} !== 2'b10 || host_read_data !== 32'h0000_00A3) begin miscompares++; $display("FAIL rst_mid_resume: got %b %h want 10 a3", {host_read_ack, host_read_error}, host_read_data); end
        dev_read_ack = '0; host_read_req = 0;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_read_unmapped();
        test_write_timeout();
        test_concurrent();
        test_boundaries();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
